// File: rtl/shift_sequencer_pkg.sv
// Shared types and elaboration helpers for the serial frame sequencer.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    function automatic bit params_ok(input int num_bits, input int clks_per_bit);
        return (num_bits >= 32'sd2) && (clks_per_bit >= 32'sd1);
    endfunction

    // A single-cycle bit period still needs a one-bit counter to exist.
    function automatic int clk_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 32'sd1) ? $clog2(clks_per_bit) : 32'sd1;
    endfunction

endpackage

// File: rtl/shift_sequencer_shift_register.sv
// Loadable shift register: shifts right, new serial bit enters at the MSB.
module shift_register #(
    parameter int                  NUM_BITS  = 8,
    parameter logic [NUM_BITS-1:0] RST_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] data_r;

    // Load takes priority over shift; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= RST_VALUE;
        end else if (load_enable) begin
            data_r <= parallel_in;
        end else if (shift_enable) begin
            data_r <= {serial_in, data_r[NUM_BITS-1:1]};
        end else begin
            data_r <= data_r;
        end
    end

    assign parallel_out = data_r;
    assign serial_out   = data_r[0];

endmodule

// File: rtl/shift_sequencer.sv
// Frame controller: loads a word, shifts it out LSB-first while capturing serial_in.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int RST_VALUE    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic                abort,
    input  logic                serial_in,
    output logic                serial_out,
    output logic                bit_strobe,
    output logic                frame_active,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rx_valid
);

    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int CLK_W = clk_cnt_width(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(NUM_BITS - 1);
    localparam logic [CLK_W-1:0]    CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [NUM_BITS-1:0] RST_WORD = NUM_BITS'(RST_VALUE);

    if (!params_ok(NUM_BITS, CLKS_PER_BIT)) begin : g_bad_params
        $error("shift_sequencer: NUM_BITS must be >= 2 and CLKS_PER_BIT >= 1");
    end

    seq_state_t       state_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [CLK_W-1:0] clk_cnt_r;
    logic             tx_ready_r;
    logic             frame_active_r;
    logic             rx_valid_r;
    logic             load_enable;
    logic             shift_enable;

    // Abort in IDLE blocks an accept in the same cycle.
    assign load_enable  = (state_r == IDLE) && tx_valid && !abort;
    assign shift_enable = (state_r == SHIFT) && (clk_cnt_r == CLK_LAST);

    // Frame FSM with bit/clock counters and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            bit_cnt_r      <= '0;
            clk_cnt_r      <= '0;
            tx_ready_r     <= 1'b1;
            frame_active_r <= 1'b0;
            rx_valid_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rx_valid_r <= 1'b0;
                    bit_cnt_r  <= '0;
                    clk_cnt_r  <= '0;
                    if (load_enable) begin
                        state_r        <= SHIFT;
                        tx_ready_r     <= 1'b0;
                        frame_active_r <= 1'b1;
                    end else begin
                        state_r        <= IDLE;
                        tx_ready_r     <= 1'b1;
                        frame_active_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    rx_valid_r <= 1'b0;
                    if (abort) begin
                        state_r        <= IDLE;
                        bit_cnt_r      <= '0;
                        clk_cnt_r      <= '0;
                        tx_ready_r     <= 1'b1;
                        frame_active_r <= 1'b0;
                    end else if (clk_cnt_r == CLK_LAST) begin
                        clk_cnt_r <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r        <= DONE;
                            bit_cnt_r      <= '0;
                            frame_active_r <= 1'b0;
                            rx_valid_r     <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    state_r        <= IDLE;
                    bit_cnt_r      <= '0;
                    clk_cnt_r      <= '0;
                    tx_ready_r     <= 1'b1;
                    frame_active_r <= 1'b0;
                    rx_valid_r     <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    bit_cnt_r      <= '0;
                    clk_cnt_r      <= '0;
                    tx_ready_r     <= 1'b1;
                    frame_active_r <= 1'b0;
                    rx_valid_r     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready     = tx_ready_r;
    assign frame_active = frame_active_r;
    assign rx_valid     = rx_valid_r;
    assign bit_strobe   = shift_enable;

    shift_register #(
        .NUM_BITS  (NUM_BITS),
        .RST_VALUE (RST_WORD)
    ) u_shift_register (
        .clk          (clk),
        .rst          (rst),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .parallel_in  (tx_data),
        .serial_in    (serial_in),
        .parallel_out (rx_data),
        .serial_out   (serial_out)
    );

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Frame controller that owns one `shift_register` instance and runs full-duplex serial word transfers through it. It accepts a parallel transmit word on a valid/ready handshake, loads it, and shifts it out LSB-first at a programmable bit rate while capturing `serial_in` at the MSB. After `NUM_BITS` shifts it presents the received word with a one-cycle valid pulse. It sits between the design's parallel datapath and the serial pins.

## Interface
- `NUM_BITS`, 8: word length; must be ≥ 2.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; must be ≥ 1.
- `RST_VALUE`, 0: register contents after reset, truncated to `NUM_BITS`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  in  NUM_BITS  word to transmit.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  block can accept a word.
- `abort`  in  1  synchronous frame abort.
- `serial_in`  in  1  receive bit, sampled on shift.
- `serial_out`  out  1  transmit bit, always register bit 0.
- `bit_strobe`  out  1  high in the cycle whose closing edge shifts.
- `frame_active`  out  1  high while a frame is in flight.
- `rx_data`  out  NUM_BITS  register contents; meaningful only with `rx_valid`.
- `rx_valid`  out  1  one-cycle pulse, received word complete.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `tx_ready`=1. Accept on `tx_valid && tx_ready`, which asserts `load_enable` that cycle. Next state is SHIFT, with the clock counter at 0 and the bit counter at 0.
- SHIFT:
  - The clock counter counts 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1, `bit_strobe`=`shift_enable`=1, the clock counter wraps to 0, and the bit counter increments.
  - A strobe with bit counter = NUM_BITS-1 is the last one; next state is DONE.
- DONE: `rx_valid`=1 for exactly one cycle, with `rx_data` = the received word, where bit i is the i-th sampled bit. Next state is IDLE.
- `tx_ready`=1 only in IDLE. `tx_valid` outside IDLE is ignored and `tx_data` is not captured.
- `abort`: in SHIFT or DONE, next state is IDLE with no `rx_valid`. It does not reload the register, so the partial contents remain. In IDLE it is ignored, and it takes priority over an accept in the same cycle. `rx_valid` is never asserted in the cycle following an abort.
- Counter widths:
  - Bit counter: `$clog2(NUM_BITS)`.
  - Clock counter: `$clog2(CLKS_PER_BIT)`, with a minimum of 1 bit.
  - Both counters are unsigned, and neither counter may wrap past its terminal value.
- Reset, including mid-frame: state IDLE, counters 0, register = RST_VALUE. Outputs after reset: `tx_ready`=1, `rx_valid`=0, `bit_strobe`=0, `frame_active`=0, `serial_out`=RST_VALUE[0]. Reset overrides `abort` and accept.

## Timing
- Accept happens in cycle 0. Bit 0 of `tx_data` is on `serial_out` from cycle 1 to cycle CLKS_PER_BIT.
- `bit_strobe` is high in cycles k·CLKS_PER_BIT for k = 1..NUM_BITS. `serial_in` is sampled at the closing edge of each strobe cycle.
- `frame_active` is high in cycles 1..NUM_BITS·CLKS_PER_BIT.
- `rx_valid` is high in cycle NUM_BITS·CLKS_PER_BIT+1. `tx_ready` returns in cycle NUM_BITS·CLKS_PER_BIT+2.
- Back-to-back frame period is NUM_BITS·CLKS_PER_BIT+2 cycles.
- With CLKS_PER_BIT=1, the block shifts every SHIFT cycle.
- All outputs are registered state or decodes of state, with no combinational path from inputs to outputs. The exception is `tx_ready`, which is a decode of state only.

## Structure
- Package `shift_sequencer_pkg`:
  - state enum `seq_state_t` {IDLE, SHIFT, DONE}.
  - elaboration-time parameter checks (NUM_BITS ≥ 2, CLKS_PER_BIT ≥ 1).
- One sub-module: `shift_register`, instantiated with NUM_BITS and RST_VALUE.
  - The sequencer drives its `load_enable` and `shift_enable`.
  - It wires `parallel_out` to `rx_data` and `serial_out` directly.
- The FSM and both counters live in the sequencer top.

## Test plan
All scenarios use NUM_BITS=8 and CLKS_PER_BIT=4.
- Reset: hold `rst` 2 cycles → `tx_ready`=1, `rx_valid`=0, `frame_active`=0, `bit_strobe`=0, `serial_out`=0.
- Loopback (`serial_in`=`serial_out`), send 0xA5 → `serial_out` pattern 1,0,1,0,0,1,0,1 with 4 cycles per bit; `rx_valid` in cycle 33 with `rx_data`=0xA5; `tx_ready` in cycle 34.
- `serial_in` tied 1, send 0x00 → `serial_out`=0 throughout the frame; `rx_data`=0xFF; exactly 8 `bit_strobe` pulses.
- `tx_valid` held high with 0x3C, then 0xC3 → second accept in cycle 34; `tx_data` changes during the frame are not captured; second `rx_valid` in cycle 67.
- `abort` asserted in cycle 14 (bit 3) → IDLE in cycle 15 with `tx_ready`=1; no `rx_valid`; a following 0x5A frame completes correctly.
- `rst` asserted in cycle 20 of a frame → next cycle shows the reset output values; no `rx_valid` follows.
